// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP weight server and the MLP compute controller.
// Optional build macro used by mlp_weight_server: MLP_WEIGHT_PARITY_EN.
package mlp_pkg;

  localparam int NUMLAYERBITS    = 4;
  localparam int NUM_LAYERS      = 4;
  localparam int DESC_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    STREAM,
    DRAIN
  } srv_state_e;

  typedef struct packed {
    logic [DESC_ADDR_WIDTH-1:0] base;
    logic [DESC_ADDR_WIDTH:0]   count;
  } layer_desc_t;

endpackage

// File: rtl/mlp_weight_fifo.sv
// Two-entry valid/ready skid FIFO with fall-through when empty, so a RAM read
// issued in cycle N is presented in cycle N+1 even with no backpressure.
module mlp_weight_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             empty, pop, store;

  assign empty       = (count_q == 2'd0);
  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = empty ? in_data_i : mem_q[rd_ptr_q];
  assign pop         = out_valid_o && out_ready_i;
  // An incoming word consumed in the same cycle it arrives never touches storage.
  assign store       = in_valid_i && !(empty && pop);
  assign count_o     = count_q;

  always_comb begin
    count_d = count_q;
    if (store)         count_d = count_d + 2'd1;
    if (pop && !empty) count_d = count_d - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (pop && !empty) rd_ptr_q <= ~rd_ptr_q;
      if (store)         wr_ptr_q <= ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/mlp_weight_server.sv
// Layer-weight responder: descriptor lookup plus credit-limited streaming from weight RAM.
// Define MLP_WEIGHT_PARITY_EN to store and check an even-parity bit per weight word.
module mlp_weight_server #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUMLAYERBITS = mlp_pkg::NUMLAYERBITS,
  parameter int NUM_LAYERS   = mlp_pkg::NUM_LAYERS,
  parameter int ADDR_WIDTH   = mlp_pkg::DESC_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [NUMLAYERBITS-1:0] cfg_layer,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH:0]     cfg_count,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    req_valid,
  input  logic [NUMLAYERBITS-1:0] req_layer,
  output logic                    req_ready,
  output logic                    w_valid,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic                    w_last,
  input  logic                    w_ready,
  output logic                    data_ready,
  output logic                    err
);
  import mlp_pkg::*;

`ifdef MLP_WEIGHT_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif
  localparam int FIFO_W = RAM_W + 1;
  localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [NUMLAYERBITS:0] LAYER_LIMIT = (NUMLAYERBITS + 1)'(NUM_LAYERS);
  localparam logic [ADDR_WIDTH:0]   ONE_LEFT    = (ADDR_WIDTH + 1)'(1);

  srv_state_e         state_q, state_d;
  layer_desc_t        desc_q [NUM_LAYERS];
  layer_desc_t        req_desc_q;
  logic               req_ok_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic               rd_valid_q, rd_last_q;
  logic [RAM_W-1:0]   ram [2**ADDR_WIDTH];
  logic [RAM_W-1:0]   rd_data_q, ram_wword;

  logic               idle, cfg_ok, req_ok, issue, credit_ok, beat_acc;
  logic               err_check, err_write, err_parity;
  logic [FIFO_W-1:0]  fifo_out;
  logic [1:0]         fifo_count;

  assign idle      = (state_q == IDLE);
  assign cfg_ok    = ({1'b0, cfg_layer} < LAYER_LIMIT);
  assign req_ok    = ({1'b0, req_layer} < LAYER_LIMIT);
  assign req_ready = idle && rst;
  // Occupancy plus the read still in flight must leave room for the next returning word.
  assign credit_ok = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && !rd_valid_q);
  assign issue     = (state_q == STREAM) && credit_ok;
  assign beat_acc  = w_valid && w_ready;
  assign err_write = (cfg_we || mem_we) && !idle;

`ifdef MLP_WEIGHT_PARITY_EN
  assign ram_wword  = {^mem_wdata, mem_wdata};
  assign err_parity = beat_acc && (^fifo_out[RAM_W-1:0]);
`else
  assign ram_wword  = mem_wdata;
  assign err_parity = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    err_check  = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      IDLE:    if (req_valid) state_d = CHECK;
      CHECK: begin
        if (!req_ok_q || (req_desc_q.count == '0)) begin
          err_check = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM:  if (issue && (remaining_q == ONE_LEFT)) state_d = DRAIN;
      DRAIN: begin
        if (beat_acc && w_last) begin
          data_ready = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err = err_check || err_write || err_parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_desc_q  <= '0;
      req_ok_q    <= 1'b0;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) desc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (idle && cfg_we && cfg_ok)
        desc_q[cfg_layer[LIDX_W-1:0]] <= '{base: cfg_base, count: cfg_count};
      // Snapshot the descriptor at acceptance so a same-cycle cfg write is not seen.
      if (idle && req_valid) begin
        req_ok_q   <= req_ok;
        req_desc_q <= req_ok ? desc_q[req_layer[LIDX_W-1:0]] : '0;
      end
      if (state_q == CHECK) begin
        rd_addr_q   <= req_desc_q.base;
        remaining_q <= req_desc_q.count;
      end else if (issue) begin
        rd_addr_q   <= rd_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      rd_valid_q <= issue;
      rd_last_q  <= issue && (remaining_q == ONE_LEFT);
    end
  end

  always_ff @(posedge clk) begin
    if (idle && mem_we) ram[mem_addr] <= ram_wword;
    if (issue)          rd_data_q     <= ram[rd_addr_q];
  end

  mlp_weight_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (rd_valid_q),
    .in_data_i  ({rd_last_q, rd_data_q}),
    .out_ready_i(w_ready),
    .out_valid_o(w_valid),
    .out_data_o (fifo_out),
    .count_o    (fifo_count)
  );

  assign w_data = fifo_out[DATA_WIDTH-1:0];
  assign w_last = fifo_out[RAM_W];

endmodule

// File: tb/tb_mlp_weight_server.sv
// Self-checking bench for mlp_weight_server: table of directed requests, hand-written
// corner sequences, and randomized traffic against an array-based reference model.
module tb_mlp_weight_server;
  localparam int DW = 32, LB = 4, NL = 4, AW = 10, DEPTH = 1024;

  logic          clk, rst;
  logic          cfg_we, mem_we, req_valid, w_ready;
  logic [LB-1:0] cfg_layer, req_layer;
  logic [AW-1:0] cfg_base, mem_addr;
  logic [AW:0]   cfg_count;
  logic [DW-1:0] mem_wdata, w_data;
  logic          req_ready, w_valid, w_last, data_ready, err;

  mlp_weight_server dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_base(cfg_base), .cfg_count(cfg_count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .req_valid(req_valid), .req_layer(req_layer), .req_ready(req_ready),
    .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .w_ready(w_ready),
    .data_ready(data_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DW-1:0] m_ram [DEPTH];
  int m_base [NL];
  int m_cnt  [NL];

  typedef struct {
    int          layer;
    int          mode;
    bit          exp_err;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cfg_we = 1'b0; mem_we = 1'b0; req_valid = 1'b0;
  endtask

  task automatic wr_mem(input int a, input logic [31:0] d);
    next_cycle();
    mem_we = 1'b1; mem_addr = AW'(a); mem_wdata = d;
    m_ram[a] = d;
  endtask

  task automatic wr_cfg(input int l, input int b, input int c);
    next_cycle();
    cfg_we = 1'b1; cfg_layer = LB'(l); cfg_base = AW'(b); cfg_count = (AW+1)'(c);
    if (l < NL) begin m_base[l] = b; m_cnt[l] = c; end
  endtask

  // mode 0: w_ready high; 1: pattern 1,0,0,1,0,1; 2: random.
  // inj_cyc: cycle (after acceptance) carrying an illegal mem_we; rst_beat: beat on which reset hits.
  task automatic run_req(input int layer, input int mode, input int inj_cyc, input int rst_beat,
                         output int nbeats, output bit saw_err,
                         output logic [31:0] first_w, output logic [31:0] last_w);
    logic [31:0] exp_q [$];
    logic [5:0]  pat;
    logic [31:0] prev_d;
    bit ok, done, stalled, prev_l, aborted;
    pat = 6'b101001;
    ok  = (layer < NL) && (m_cnt[layer] != 0);
    if (ok) for (int i = 0; i < m_cnt[layer]; i++) exp_q.push_back(m_ram[(m_base[layer] + i) % DEPTH]);
    nbeats = 0; saw_err = 0; first_w = '0; last_w = '0;
    done = 0; stalled = 0; prev_d = '0; prev_l = 0; aborted = 0;
    next_cycle();
    req_valid = 1'b1; req_layer = LB'(layer); w_ready = 1'b1;
    #1 chk("req_ready_at_accept", req_ready, 1);
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      next_cycle();
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = pat[cyc % 6];
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == inj_cyc) begin mem_we = 1'b1; mem_addr = 10'd3; mem_wdata = 32'hDEAD_BEEF; end
      #1;
      if (err) saw_err = 1;
      chk("err_pulse", err, ((cyc == 1) && !ok) || (cyc == inj_cyc));
      if (!ok) begin
        chk("no_beat_on_error", w_valid, 0);
        if (cyc >= 3) done = 1;
      end else begin
        if (cyc < 3)  chk("early_valid", w_valid, 0);
        if (cyc == 3) chk("first_beat_latency", w_valid, 1);
        if (stalled) begin
          chk("stall_valid", w_valid, 1);
          chk("stall_data", w_data, prev_d);
          chk("stall_last", w_last, prev_l);
        end
        if (rst_beat > 0 && w_valid && nbeats == rst_beat - 1) begin
          rst = 1'b0;
          #1;
          chk("rst_kills_valid", w_valid, 0);
          chk("rst_no_data_ready", data_ready, 0);
          chk("rst_req_ready", req_ready, 0);
          done = 1; aborted = 1;
        end else if (w_valid && w_ready) begin
          if (nbeats < exp_q.size()) chk("beat_data", w_data, exp_q[nbeats]);
          chk("beat_last", w_last, nbeats == exp_q.size() - 1);
          chk("data_ready", data_ready, nbeats == exp_q.size() - 1);
          if (nbeats == 0) first_w = w_data;
          last_w = w_data;
          nbeats++;
          if (nbeats >= exp_q.size()) done = 1;
        end else begin
          chk("data_ready_quiet", data_ready, 0);
        end
        stalled = w_valid && !w_ready;
        prev_d = w_data; prev_l = w_last;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d beats, expected %0d for layer %0d", nbeats, exp_q.size(), layer);
    end
    if (!aborted) begin
      next_cycle();
      w_ready = 1'b0;
      #1 chk("back_to_idle", req_ready, 1);
    end
  endtask

  int          nb;
  bit          se;
  logic [31:0] fw, lw;

  initial begin
    rst = 1'b0; cfg_we = 0; mem_we = 0; req_valid = 0; w_ready = 0;
    cfg_layer = '0; cfg_base = '0; cfg_count = '0; mem_addr = '0; mem_wdata = '0; req_layer = '0;
    for (int i = 0; i < NL; i++) begin m_base[i] = 0; m_cnt[i] = 0; end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 0);
    next_cycle();
    rst = 1'b1;
    #1 chk("idle_req_ready", req_ready, 1);

    for (int i = 0; i < DEPTH; i++) wr_mem(i, 32'hC000_0000 | i);
    for (int i = 0; i < 5; i++) wr_mem(i, 32'h10 + i);
    wr_mem(1022, 32'hAA0);
    wr_mem(1023, 32'hAA1);
    wr_cfg(1, 2, 3);
    wr_cfg(3, 1022, 4);
    wr_cfg(0, 0, 6);
    // Descriptor write and RAM write in the same cycle: both must land.
    next_cycle();
    cfg_we = 1'b1; cfg_layer = 4'd2; cfg_base = 10'd5; cfg_count = '0;
    mem_we = 1'b1; mem_addr = 10'd5; mem_wdata = 32'h15;
    m_base[2] = 5; m_cnt[2] = 0; m_ram[5] = 32'h15;

    vecs[0] = '{layer: 1, mode: 0, exp_err: 0, exp_beats: 3, exp_first: 32'h12,  exp_last: 32'h14};
    vecs[1] = '{layer: 1, mode: 1, exp_err: 0, exp_beats: 3, exp_first: 32'h12,  exp_last: 32'h14};
    vecs[2] = '{layer: 7, mode: 0, exp_err: 1, exp_beats: 0, exp_first: 32'h0,   exp_last: 32'h0};
    vecs[3] = '{layer: 2, mode: 0, exp_err: 1, exp_beats: 0, exp_first: 32'h0,   exp_last: 32'h0};
    vecs[4] = '{layer: 3, mode: 0, exp_err: 0, exp_beats: 4, exp_first: 32'hAA0, exp_last: 32'h11};
    vecs[5] = '{layer: 0, mode: 2, exp_err: 0, exp_beats: 6, exp_first: 32'h10,  exp_last: 32'h15};
    for (int v = 0; v < 6; v++) begin
      run_req(vecs[v].layer, vecs[v].mode, 0, 0, nb, se, fw, lw);
      chk("tbl_err", se, vecs[v].exp_err);
      chk("tbl_beats", nb, vecs[v].exp_beats);
      if (!vecs[v].exp_err) begin
        chk("tbl_first", fw, vecs[v].exp_first);
        chk("tbl_last", lw, vecs[v].exp_last);
      end
    end

    // Illegal RAM write mid-stream: err pulse, stream intact, RAM untouched.
    run_req(0, 1, 4, 0, nb, se, fw, lw);
    chk("inj_beats", nb, 6);
    run_req(1, 0, 0, 0, nb, se, fw, lw);
    chk("inj_ram_unchanged", fw, 32'h12);

    // Reset on the second beat of a three-beat stream.
    run_req(1, 0, 0, 2, nb, se, fw, lw);
    chk("abort_beats", nb, 1);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < NL; i++) begin m_base[i] = 0; m_cnt[i] = 0; end

    // Same-cycle cfg write and request: request sees the cleared descriptor.
    next_cycle();
    cfg_we = 1'b1; cfg_layer = 4'd1; cfg_base = 10'd2; cfg_count = 11'd3;
    req_valid = 1'b1; req_layer = 4'd1;
    #1 chk("simul_req_ready", req_ready, 1);
    next_cycle();
    #1;
    chk("simul_old_desc_err", err, 1);
    chk("simul_no_valid", w_valid, 0);
    m_base[1] = 2; m_cnt[1] = 3;
    next_cycle();
    #1 chk("simul_idle", req_ready, 1);
    run_req(1, 0, 0, 0, nb, se, fw, lw);
    chk("post_reset_first", fw, 32'h12);
    chk("post_reset_beats", nb, 3);

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 3; k++) wr_mem($urandom_range(0, DEPTH - 1), $urandom);
      wr_cfg($urandom_range(0, NL - 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 9));
      run_req($urandom_range(0, 5), 2, 0, 0, nb, se, fw, lw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_weight_server.md
Name: mlp_weight_server

Overview:
- Responder side of the MLP layer-weight fetch interface.
- The MLP controller requests a layer index. This block looks up that layer's descriptor (base address, word count) and streams the layer's weight words from an internal synchronous-read weight RAM, using a valid/ready handshake.
- A loader port fills the RAM and the descriptor table before inference.
- Sits between the weight loader (host/DMA) and the MLP compute controller.

Parameters:
- DATA_WIDTH, 32, width of one weight word
- NUMLAYERBITS, 4, bits of the layer index
- NUM_LAYERS, 4, number of valid layers; descriptor table depth
- ADDR_WIDTH, 10, weight RAM address width; depth is 2**ADDR_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  write descriptor
- cfg_layer  in  NUMLAYERBITS  descriptor index
- cfg_base  in  ADDR_WIDTH  first RAM address of the layer
- cfg_count  in  ADDR_WIDTH+1  number of words in the layer
- mem_we  in  1  weight RAM write
- mem_addr  in  ADDR_WIDTH  RAM write address
- mem_wdata  in  DATA_WIDTH  RAM write data
- req_valid  in  1  layer request
- req_layer  in  NUMLAYERBITS  requested layer
- req_ready  out  1  high only in IDLE
- w_valid  out  1  weight beat valid
- w_data  out  DATA_WIDTH  weight word
- w_last  out  1  final beat of the layer
- w_ready  in  1  consumer accepts the beat
- data_ready  out  1  1-cycle pulse on acceptance of the last beat
- err  out  1  1-cycle error pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; w_valid, w_last, data_ready and err = 0; req_ready = 0 while in reset.
  - Descriptor table cleared to base=0, count=0. RAM contents are not reset.
- States: IDLE, CHECK, STREAM, DRAIN.
- IDLE:
  - req_ready=1.
  - cfg_we and mem_we are honoured only here, one write per cycle each.
  - On req_valid: latch req_layer, go to CHECK.
- CHECK (1 cycle):
  - If req_layer>=NUM_LAYERS or count==0: err pulse, return to IDLE, no beats issued.
  - Otherwise load rd_addr=base and remaining=count, go to STREAM.
- STREAM:
  - Issue one RAM read per cycle while credits allow (output FIFO occupancy + reads in flight < 2). RAM read latency is 1 cycle.
  - Each issue increments rd_addr, wrapping modulo 2**ADDR_WIDTH, and decrements remaining.
  - When remaining reaches 0: go to DRAIN.
- DRAIN:
  - Wait until the final beat is accepted (w_valid & w_ready & w_last).
  - Pulse data_ready in that same cycle; next state IDLE.
- Latency and throughput:
  - Request accepted in cycle T: CHECK in T+1, first read in T+2, first w_valid in T+3.
  - With w_ready held high: one beat per cycle, no bubbles.
- Handshake:
  - w_data and w_last stay stable while w_valid=1 and w_ready=0.
  - w_last is asserted on beat number count exactly.
- Writes outside IDLE:
  - cfg_we or mem_we outside IDLE is ignored and pulses err.
  - The stream in progress is unaffected.
- Simultaneous events:
  - cfg_we together with req_valid in IDLE: the write completes first; the request uses the newly written descriptor only if it is issued a later cycle.
  - mem_we and cfg_we in the same cycle are both performed.
- Reset mid-stream: the stream is aborted immediately; no data_ready pulse.

Optional Feature:
- Macro MLP_WEIGHT_PARITY_EN.
- With the macro defined:
  - The RAM stores one extra even-parity bit per word, computed on mem_wdata.
  - On each beat leaving the FIFO, parity is checked; on mismatch err pulses in the cycle the beat is accepted.
  - The beat is still delivered.
- Without it: no parity storage, and err comes only from descriptor or write-timing errors.

Decomposition:
- Package mlp_pkg holds:
  - the server-state enum typedef;
  - the descriptor struct typedef (base, count);
  - the constants NUM_LAYERS and NUMLAYERBITS, shared with the MLP controller.
- One sub-module: mlp_weight_fifo, a 2-entry valid/ready skid FIFO that absorbs the 1-cycle RAM latency under backpressure.

Test Plan:
- Load RAM[0..5]=0x10..0x15; descriptor layer1={base 2, count 3}; request layer 1 with w_ready=1 -> beats 0x12, 0x13, 0x14 in T+3..T+5; w_last and data_ready on 0x14.
- Same request, w_ready toggled 1,0,0,1,0,1 -> same three words in order, data stable while stalled, no drop or duplicate.
- Request layer 7 (>=NUM_LAYERS), then layer 2 with count=0 -> err pulse in CHECK each time, no w_valid, back in IDLE with req_ready=1.
- Descriptor {base 1022, count 4}, ADDR_WIDTH=10 -> addresses read in order 1022, 1023, 0, 1.
- mem_we asserted during STREAM -> err pulse, RAM unchanged, stream completes normally.
- rst low on the 2nd beat of a 3-beat stream -> w_valid=0 immediately, no data_ready; after release, the next request streams correctly from its base.
